// File: rtl/image_rom_streamer.sv
// rtl/image_rom_streamer.sv - sequential ImageROM reader presenting one word per cycle on a valid/ready stream
// Walks BASE_ADDR .. BASE_ADDR+NUM_WORDS-1 with start/abort/done control and a single output register.
module image_rom_streamer #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned NUM_WORDS = 160000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd,
  output logic [31:0] px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [23:0] LAST_IDX = 24'(NUM_WORDS - 1);

  state_t      state_q, state_d;
  logic [23:0] idx_q, idx_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] px_data_q, px_data_d;
  logic        px_valid_q, px_valid_d;
  logic        px_last_q, px_last_d;
  logic        done_q, done_d;

  logic load;
  logic xfer;

  // The ROM read is combinational, so the output register can reload whenever it is empty or draining.
  assign load = !px_valid_q || px_ready;
  assign xfer = px_valid_q && px_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    px_data_d  = px_data_q;
    px_valid_d = px_valid_q;
    px_last_d  = px_last_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d      = 24'd0;
        rom_addr_d = BASE_ADDR;
        px_valid_d = 1'b0;
        px_last_d  = 1'b0;
        if (start && !abort) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load) begin
          px_data_d  = rom_rd;
          px_valid_d = 1'b1;
          px_last_d  = (idx_q == LAST_IDX);
          idx_d      = idx_q + 24'd1;
          rom_addr_d = rom_addr_q + 32'd1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && px_last_q) begin
          px_valid_d = 1'b0;
          px_last_d  = 1'b0;
          done_d     = 1'b1;
          idx_d      = 24'd0;
          rom_addr_d = BASE_ADDR;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats every in-flight event, including the final transfer, and suppresses done.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      idx_d      = 24'd0;
      rom_addr_d = BASE_ADDR;
      px_valid_d = 1'b0;
      px_last_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 24'd0;
      rom_addr_q <= BASE_ADDR;
      px_data_q  <= 32'd0;
      px_valid_q <= 1'b0;
      px_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      px_data_q  <= px_data_d;
      px_valid_q <= px_valid_d;
      px_last_q  <= px_last_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign px_data  = px_data_q;
  assign px_valid = px_valid_q;
  assign px_last  = px_last_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_image_rom_streamer.sv
// tb/tb_image_rom_streamer.sv - self-checking bench for image_rom_streamer
// Scoreboard expects words (BASE+k)*3 in order, px_last on the final one and done one cycle later.
module tb_image_rom_streamer;

  localparam logic [31:0] BASE = 32'd100;
  localparam int          NW   = 4;

  logic        clk = 1'b0;
  logic        reset, start, abort, px_ready;
  logic [31:0] rom_addr, rom_rd, px_data;
  logic        px_valid, px_last, busy, done;

  logic        start1, abort1, px_ready1;
  logic [31:0] rom_addr1, rom_rd1, px_data1;
  logic        px_valid1, px_last1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_rd  = rom_addr * 32'd3;
  assign rom_rd1 = rom_addr1 * 32'd3;

  image_rom_streamer #(.BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_rd(rom_rd),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last),
    .busy(busy), .done(done)
  );

  image_rom_streamer #(.BASE_ADDR(BASE), .NUM_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .rom_addr(rom_addr1), .rom_rd(rom_rd1),
    .px_data(px_data1), .px_valid(px_valid1), .px_ready(px_ready1), .px_last(px_last1),
    .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high, 1: ready low in cycles 2..4, 2: alternating + mid-pass start, 3: random
  task automatic run_pass(input int mode, output int done_cyc, output int nxfer);
    int          k;
    logic        last_prev;
    logic        hold_v;
    logic [31:0] hold_d;
    k = 0; last_prev = 1'b0; hold_v = 1'b0; hold_d = 32'd0; done_cyc = -1;
    start = 1'b1;
    px_ready = 1'b1;
    step();
    for (int c = 1; c < 80; c++) begin
      start = 1'b0;
      case (mode)
        0: px_ready = 1'b1;
        1: px_ready = !(c >= 2 && c <= 4);
        2: begin
          px_ready = (c % 2 == 1);
          start = (c == 3);
        end
        default: begin
          px_ready = ($urandom_range(0, 1) == 1);
          start = ($urandom_range(0, 3) == 0);
        end
      endcase
      check("done", done, last_prev);
      if (hold_v) begin
        check("hold_valid", px_valid, 1);
        check("hold_data", px_data, hold_d);
      end
      if (mode == 1 && c >= 2 && c <= 4) check("stall_addr", rom_addr, BASE + 1);
      if (last_prev) begin
        done_cyc = c;
        start = 1'b0;
        check("end_busy", busy, 0);
        check("end_valid", px_valid, 0);
        check("end_addr", rom_addr, BASE);
        step();
        check("done_one_cycle", done, 0);
        break;
      end
      check("busy", busy, 1);
      if (px_valid && px_ready) begin
        check("data", px_data, (BASE + 32'(k)) * 32'd3);
        check("last", px_last, (k == NW - 1) ? 1 : 0);
        if (k == NW - 1) last_prev = 1'b1;
        k++;
      end
      hold_v = px_valid && !px_ready;
      hold_d = px_data;
      step();
    end
    start = 1'b0;
    px_ready = 1'b1;
    nxfer = k;
    if (done_cyc < 0) check("pass_timeout", 0, 1);
  endtask

  int dc, nx;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; px_ready1 = 1'b1;
    step(); step();
    check("rst_addr", rom_addr, BASE);
    check("rst_data", px_data, 0);
    check("rst_valid", px_valid, 0);
    check("rst_last", px_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst1_addr", rom_addr1, BASE);
    reset = 1'b0;
    step();

    run_pass(0, dc, nx);
    check("s1_done_cycle", dc, 6);
    check("s1_xfers", nx, 4);

    run_pass(1, dc, nx);
    check("s2_done_cycle", dc, 9);
    check("s2_xfers", nx, 4);

    run_pass(2, dc, nx);
    check("s3_xfers", nx, 4);

    // Abort in cycle 3 while the second word is on the bus
    start = 1'b1; step();
    start = 1'b0; step();
    step();
    abort = 1'b1;
    check("ab_data_c3", px_data, 303);
    step();
    abort = 1'b0;
    check("ab_valid", px_valid, 0);
    check("ab_busy", busy, 0);
    check("ab_last", px_last, 0);
    check("ab_addr", rom_addr, BASE);
    for (int i = 0; i < 5; i++) begin
      check("ab_no_done", done, 0);
      step();
    end
    run_pass(0, dc, nx);
    check("ab_replay_done_cycle", dc, 6);

    // start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1; step();
    start = 1'b0; abort = 1'b0;
    check("sa_idle_busy", busy, 0);
    step();
    check("sa_idle_valid", px_valid, 0);

    // Reset in cycle 3 of a pass
    start = 1'b1; step();
    start = 1'b0; step();
    step();
    reset = 1'b1;
    step();
    check("mr_addr", rom_addr, BASE);
    check("mr_data", px_data, 0);
    check("mr_valid", px_valid, 0);
    check("mr_last", px_last, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mr_no_done", done, 0);
      step();
    end

    // Single-word image
    start1 = 1'b1; step();
    start1 = 1'b0;
    check("n1_busy_c1", busy1, 1);
    check("n1_valid_c1", px_valid1, 0);
    step();
    check("n1_valid_c2", px_valid1, 1);
    check("n1_data_c2", px_data1, 300);
    check("n1_last_c2", px_last1, 1);
    check("n1_done_c2", done1, 0);
    step();
    check("n1_done_c3", done1, 1);
    check("n1_busy_c3", busy1, 0);
    check("n1_valid_c3", px_valid1, 0);
    step();
    check("n1_done_c4", done1, 0);

    for (int p = 0; p < 12; p++) begin
      run_pass(3, dc, nx);
      check("rnd_xfers", nx, 4);
      repeat ($urandom_range(0, 3)) begin
        check("rnd_idle_done", done, 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
